// File: rtl/vga_pixel_bus.sv
// VGA timing generator with a latency-matched, blank-gated RGB output register.
// Upstream source receives coordinates and returns RGB PIX_LATENCY pixel ticks later.
module vga_pixel_bus #(
    parameter int unsigned COLOR_BITS  = 8,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter bit          SYNC_POL    = 1'b0,
    parameter int unsigned PIX_LATENCY = 2,
    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW         = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
    localparam int unsigned VW         = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1,
    localparam int unsigned DW         = 3 * COLOR_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pixel_en,
    input  logic [COLOR_BITS-1:0] pixel_R,
    input  logic [COLOR_BITS-1:0] pixel_G,
    input  logic [COLOR_BITS-1:0] pixel_B,
    output logic [HW-1:0]         pixel_x,
    output logic [VW-1:0]         pixel_y,
    output logic                  pixel_req,
    output logic                  frame_start,
    output logic [DW-1:0]         vga_data,
    output logic                  vga_h_sync,
    output logic                  vga_v_sync,
    output logic                  vga_blank
);

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
    } flags_t;

    localparam flags_t FLAGS_IDLE = '0;

    logic          h_last;
    logic          v_last;
    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;
    flags_t        flags_s0;
    flags_t        flags_dly;

    // Next counter values; vertical advances only on horizontal wrap.
    always_comb begin
        h_last = (pixel_x == HW'(H_TOTAL - 1));
        v_last = (pixel_y == VW'(V_TOTAL - 1));
        h_next = h_last ? '0 : pixel_x + HW'(1);
        v_next = pixel_y;
        if (h_last) begin
            v_next = v_last ? '0 : pixel_y + VW'(1);
        end
    end

    // Counters park at the last position in reset so the first tick lands on (0,0).
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_x     <= HW'(H_TOTAL - 1);
            pixel_y     <= VW'(V_TOTAL - 1);
            pixel_req   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_en & h_last & v_last;
            if (pixel_en) begin
                pixel_x   <= h_next;
                pixel_y   <= v_next;
                pixel_req <= (32'(h_next) < H_ACTIVE) && (32'(v_next) < V_ACTIVE);
            end
        end
    end

    // Timing flags for the coordinate currently presented to the source.
    always_comb begin
        flags_s0.active = pixel_req;
        flags_s0.hs     = (32'(pixel_x) >= HS_START) && (32'(pixel_x) < HS_END);
        flags_s0.vs     = (32'(pixel_y) >= VS_START) && (32'(pixel_y) < VS_END);
    end

    // Flags follow the source pipeline so they meet the RGB they belong to.
    generate
        if (PIX_LATENCY == 0) begin : g_no_dly
            assign flags_dly = flags_s0;
        end else begin : g_dly
            flags_t stage [PIX_LATENCY];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int unsigned i = 0; i < PIX_LATENCY; i++) begin
                        stage[i] <= FLAGS_IDLE;
                    end
                end else if (pixel_en) begin
                    stage[0] <= flags_s0;
                    for (int unsigned i = 1; i < PIX_LATENCY; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign flags_dly = stage[PIX_LATENCY-1];
        end
    endgenerate

    // Pin register: RGB gated to zero outside the visible area.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_data   <= '0;
            vga_blank  <= 1'b1;
            vga_h_sync <= ~SYNC_POL;
            vga_v_sync <= ~SYNC_POL;
        end else if (pixel_en) begin
            vga_data   <= flags_dly.active ? {pixel_R, pixel_G, pixel_B} : '0;
            vga_blank  <= ~flags_dly.active;
            vga_h_sync <= flags_dly.hs ? SYNC_POL : ~SYNC_POL;
            vga_v_sync <= flags_dly.vs ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_pixel_bus.sv
// Bench for vga_pixel_bus: small raster, a modelled source pipeline and an expected-output queue.
module tb_vga_pixel_bus;

    localparam int unsigned CB  = 8;
    localparam int unsigned HA  = 8;
    localparam int unsigned HF  = 2;
    localparam int unsigned HS  = 3;
    localparam int unsigned HB  = 3;
    localparam int unsigned VA  = 4;
    localparam int unsigned VF  = 1;
    localparam int unsigned VS  = 2;
    localparam int unsigned VB  = 1;
    localparam int unsigned LAT = 2;
    localparam int HT = 16;
    localparam int VT = 8;

    typedef struct packed {
        logic [23:0] data;
        logic        blank;
        logic        hs;
        logic        vs;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pixel_en = 1'b0;
    logic [CB-1:0] pixel_R = '0;
    logic [CB-1:0] pixel_G = '0;
    logic [CB-1:0] pixel_B = '0;

    logic [3:0]  n_x, p_x;
    logic [2:0]  n_y, p_y;
    logic        n_req, p_req, n_fs, p_fs;
    logic [23:0] n_data, p_data;
    logic        n_hs, p_hs, n_vs, p_vs, n_blank, p_blank;

    vga_pixel_bus #(
        .COLOR_BITS(CB), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIX_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .pixel_en(pixel_en),
        .pixel_R(pixel_R), .pixel_G(pixel_G), .pixel_B(pixel_B),
        .pixel_x(n_x), .pixel_y(n_y), .pixel_req(n_req), .frame_start(n_fs),
        .vga_data(n_data), .vga_h_sync(n_hs), .vga_v_sync(n_vs), .vga_blank(n_blank)
    );

    vga_pixel_bus #(
        .COLOR_BITS(CB), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b1), .PIX_LATENCY(LAT)
    ) dut_p (
        .clk(clk), .reset(reset), .pixel_en(pixel_en),
        .pixel_R(pixel_R), .pixel_G(pixel_G), .pixel_B(pixel_B),
        .pixel_x(p_x), .pixel_y(p_y), .pixel_req(p_req), .frame_start(p_fs),
        .vga_data(p_data), .vga_h_sync(p_hs), .vga_v_sync(p_vs), .vga_blank(p_blank)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          mh = HT - 1;
    int          mv = VT - 1;
    logic [23:0] src0 = '0;
    logic [23:0] src1 = '0;
    bit          exp_fs = 1'b0;
    exp_t        cur;
    exp_t        blank_e;
    exp_t        q[$];

    function automatic exp_t coord_exp(int h, int v);
        exp_t e;
        bit   act;
        act     = (h < int'(HA)) && (v < int'(VA));
        e.data  = act ? {8'(h), 8'(v), 8'hA5} : 24'h0;
        e.blank = !act;
        e.hs    = (h >= int'(HA + HF)) && (h < int'(HA + HF + HS));
        e.vs    = (v >= int'(VA + VF)) && (v < int'(VA + VF + VS));
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clk: drive inputs, advance the model, compare every output of both instances.
    task automatic step(input bit en, input bit rst);
        bit   req;
        pixel_en = en;
        reset    = rst;
        @(posedge clk);
        #1;
        if (en) begin
            src1 = src0;
            src0 = {8'(mh), 8'(mv), 8'hA5};
        end
        if (rst) begin
            mh = HT - 1;
            mv = VT - 1;
            q.delete();
            repeat (LAT + 1) q.push_back(blank_e);
            cur    = blank_e;
            exp_fs = 1'b0;
        end else if (en) begin
            exp_fs = (mh == HT - 1) && (mv == VT - 1);
            cur    = q.pop_front();
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            q.push_back(coord_exp(mh, mv));
        end else begin
            exp_fs = 1'b0;
        end
        {pixel_R, pixel_G, pixel_B} = src1;
        req = (mh < int'(HA)) && (mv < int'(VA)) && !rst;

        check("pixel_x",     32'(n_x),     32'(mh));
        check("pixel_y",     32'(n_y),     32'(mv));
        check("pixel_req",   32'(n_req),   32'(req));
        check("frame_start", 32'(n_fs),    32'(exp_fs));
        check("vga_data",    32'(n_data),  32'(cur.data));
        check("vga_blank",   32'(n_blank), 32'(cur.blank));
        check("h_sync",      32'(n_hs),    32'(cur.hs ? 1'b0 : 1'b1));
        check("v_sync",      32'(n_vs),    32'(cur.vs ? 1'b0 : 1'b1));
        check("pol_data",    32'(p_data),  32'(cur.data));
        check("pol_fs",      32'(p_fs),    32'(exp_fs));
        check("pol_h_sync",  32'(p_hs),    32'(cur.hs ? 1'b1 : 1'b0));
        check("pol_v_sync",  32'(p_vs),    32'(cur.vs ? 1'b1 : 1'b0));
    endtask

    initial begin
        blank_e = '{data: 24'h0, blank: 1'b1, hs: 1'b0, vs: 1'b0};
        cur     = blank_e;

        // Reset held with pixel_en high
        repeat (3) step(1'b1, 1'b1);

        // Two full-rate frames: frame start, latency, line data, sync windows
        repeat (2 * HT * VT + 3) step(1'b1, 1'b0);

        // Pixel clock at one quarter rate
        for (int i = 0; i < 4 * HT * VT; i++) step((i % 4) == 0, 1'b0);

        // Run to pixel (5,2) then reset mid-frame
        for (int i = 0; i < HT * VT && !(mh == 5 && mv == 2); i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        // Restart after reset, including idle clocks before the first tick
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        repeat (HT * VT + 8) step(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pixel_bus.md
Name: vga_pixel_bus

Overview:
Parametrised VGA pixel bus with an integrated timing generator. It produces pixel coordinates and a request flag for the upstream background/sprite source. It accepts that source's RGB after a fixed pipeline latency and drives a registered, blank-gated RGB bus with h/v sync delayed to match. Sits between the background renderer and the VGA DAC pins.

Parameters:
COLOR_BITS, 8, bits per colour channel; vga_data is 3*COLOR_BITS wide, ordered {R,G,B}
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
SYNC_POL, 0, asserted sync level (0 = active-low)
PIX_LATENCY, 2, pixel_en ticks from coordinate presentation to valid pixel_R/G/B; range 0..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
pixel_en  in  1  pixel-clock enable tick; all state advances only when 1
pixel_R  in  COLOR_BITS  red from source, valid PIX_LATENCY ticks after its coordinate
pixel_G  in  COLOR_BITS  green, same timing
pixel_B  in  COLOR_BITS  blue, same timing
pixel_x  out  clog2(H_TOTAL)  current horizontal count (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP)
pixel_y  out  clog2(V_TOTAL)  current vertical count
pixel_req  out  1  high when (pixel_x < H_ACTIVE) and (pixel_y < V_ACTIVE)
frame_start  out  1  one-clk pulse when counters move to (0,0)
vga_data  out  3*COLOR_BITS  registered RGB, forced to 0 during blanking
vga_h_sync  out  1  horizontal sync, aligned with vga_data
vga_v_sync  out  1  vertical sync, aligned with vga_data
vga_blank  out  1  high when vga_data is outside the active area

Behaviour:
- Clocking/reset: one clock, clk. reset is synchronous and active-high. It wins over pixel_en.
- Reset state:
  - counters = (H_TOTAL-1, V_TOTAL-1), so pixel_req = 0.
  - frame_start = 0, vga_data = 0, vga_blank = 1.
  - both syncs at the inactive level ~SYNC_POL.
  - all delay-line stages cleared to blank/inactive.
- Counters, on a clk edge with pixel_en = 1:
  - h = (h == H_TOTAL-1) ? 0 : h+1.
  - On h wrap: v = (v == V_TOTAL-1) ? 0 : v+1.
  - Counters hold when pixel_en = 0.
- frame_start:
  - Set on the edge where both counters wrap to (0,0).
  - Cleared on the next clk edge regardless of pixel_en, so it is exactly one clk wide.
- Stage-0 flags, decoded from the counters:
  - active = pixel_req.
  - hs = 1 when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs uses the same window rule on v with the V_* parameters.
- Delay line:
  - {active, hs, vs} pass through PIX_LATENCY stages, shifting only on pixel_en.
  - With PIX_LATENCY = 0 there is no delay stage.
- Output register, updated on an edge with pixel_en = 1:
  - vga_data = delayed active ? {pixel_R, pixel_G, pixel_B} : 0.
  - vga_blank = ~delayed active.
  - vga_h_sync = delayed hs ? SYNC_POL : ~SYNC_POL; vga_v_sync likewise from delayed vs.
- Total latency: counter value to output pins is PIX_LATENCY+1 pixel_en ticks. The syncs carry the same latency as the data.
- Source contract: the source advances its own pipeline only on pixel_en. RGB sampled while delayed active = 0 is ignored.
- Reset mid-frame: everything returns to the reset state within the same edge. The first pixel_en after reset releases moves the counters to (0,0) and pulses frame_start. There is no partial-frame output; the pipeline drains as blank.
- pixel_en held high continuously is legal (full-rate pixel clock).

Test Plan:
Bench parameters for all scenarios unless stated: H 8/2/3/3 (H_TOTAL 16), V 4/1/2/1 (V_TOTAL 8), PIX_LATENCY 2, COLOR_BITS 8.
1. Reset values: hold reset 3 clks with pixel_en = 1 -> pixel_x = 15, pixel_y = 7, pixel_req = 0, vga_data = 0, vga_blank = 1, both syncs = 1.
2. Frame start: release reset with pixel_en = 1 -> next clk has pixel_x = 0, pixel_y = 0, pixel_req = 1 and a one-clk frame_start. Repeats every 128 ticks.
3. Latency alignment: source returns R = x, G = y, B = 0xA5 with 2-tick latency -> vga_data = {0x00,0x00,0xA5} exactly 3 ticks after (0,0) is presented. vga_blank falls in the same clk. Line data x = 0..7 appears, then zeros.
4. Sync timing: vga_h_sync is low for ticks h = 10..12, delayed 3. vga_v_sync is low for lines 5..6. Data = 0 throughout.
5. pixel_en = 1 every 4th clk -> counters, data and syncs advance once per tick and hold otherwise. frame_start stays one clk wide.
6. Reset at pixel (5,2), then SYNC_POL = 1 variant -> immediate return to the reset values of scenario 1. With SYNC_POL = 1 the inactive level is 0 and the sync pulses are high.
